// File: rtl/serial_frame_rx_4bit.sv
// Asynchronous serial frame receiver: start, DATA_W data bits LSB-first, raw parity, stop.
// Delivers data and parity through a one-deep ready/valid holding register.
module serial_frame_rx_4bit #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_i,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] D,
    output logic              parity,
    output logic              framing_err,
    output logic              overrun,
    output logic              busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_BREAK
    } state_t;

    state_t            r_state, w_next;
    logic [CW-1:0]     r_cnt, w_cnt_next;
    logic [IW-1:0]     r_idx, w_idx_next;
    logic [DATA_W-1:0] r_shift, w_shift_next;
    logic              r_par_sh, w_par_sh_next;
    logic              r_sync1, r_sync2;
    logic              r_valid, r_par, r_ferr, r_ovr;
    logic [DATA_W-1:0] r_d;
    logic              w_rx_s, w_good, w_ferr;

    assign w_rx_s = r_sync2;

    // Synchroniser flops start high so reset looks like an idle line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx_i;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_par_sh <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt_next;
            r_idx    <= w_idx_next;
            r_shift  <= w_shift_next;
            r_par_sh <= w_par_sh_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_cnt_next    = r_cnt + CW'(1);
        w_idx_next    = r_idx;
        w_shift_next  = r_shift;
        w_par_sh_next = r_par_sh;
        w_good        = 1'b0;
        w_ferr        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (!w_rx_s) w_next = S_START;
            end
            S_START: begin
                if (r_cnt == CNT_MID) begin
                    w_cnt_next = '0;
                    if (w_rx_s) begin
                        w_next = S_IDLE;
                    end else begin
                        w_next     = S_DATA;
                        w_idx_next = '0;
                    end
                end
            end
            S_DATA: begin
                if (r_cnt == CNT_END) begin
                    w_cnt_next = '0;
                    for (int i = 0; i < DATA_W; i++) begin
                        if (r_idx == IW'(i)) w_shift_next[i] = w_rx_s;
                    end
                    if (r_idx == IDX_LAST) w_next = S_PAR;
                    else                   w_idx_next = r_idx + IW'(1);
                end
            end
            S_PAR: begin
                if (r_cnt == CNT_END) begin
                    w_cnt_next    = '0;
                    w_par_sh_next = w_rx_s;
                    w_next        = S_STOP;
                end
            end
            S_STOP: begin
                if (r_cnt == CNT_END) begin
                    w_cnt_next = '0;
                    if (w_rx_s) begin
                        w_good = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_ferr = 1'b1;
                        w_next = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                w_cnt_next = '0;
                if (w_rx_s) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // A finished frame may replace the held one only if that one leaves this same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_d     <= '0;
            r_par   <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            if (w_good && (!r_valid || out_ready)) begin
                r_valid <= 1'b1;
                r_d     <= r_shift;
                r_par   <= r_par_sh;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
            r_ovr  <= w_good && r_valid && !out_ready;
            r_ferr <= w_ferr;
        end
    end

    assign out_valid   = r_valid;
    assign D           = r_d;
    assign parity      = r_par;
    assign framing_err = r_ferr;
    assign overrun     = r_ovr;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_serial_frame_rx_4bit.sv
// Directed bench for serial_frame_rx_4bit: frames are driven bit by bit on the falling edge
// and a monitor tallies handshakes and flag pulses a little after each falling edge.
module tb_serial_frame_rx_4bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_i;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] D;
    logic       parity;
    logic       framing_err;
    logic       overrun;
    logic       busy;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         startCyc = 0;
    int         riseCyc = -1;
    int         accCount = 0;
    int         ovCount = 0;
    int         feCount = 0;
    logic [3:0] accD = '0;
    logic       accPar = 1'b0;
    logic       prevValid = 1'b0;
    int         a0, o0, f0;

    serial_frame_rx_4bit #(.CLKS_PER_BIT(16), .DATA_W(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_i(rx_i),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .D(D),
        .parity(parity),
        .framing_err(framing_err),
        .overrun(overrun),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe between the falling edge (where inputs change) and the next rising edge.
    always @(negedge clk) begin
        #2;
        if (out_valid && out_ready) begin
            accCount++;
            accD   = D;
            accPar = parity;
        end
        if (overrun) ovCount++;
        if (framing_err) feCount++;
        if (out_valid && !prevValid) riseCyc = cyc;
        prevValid = out_valid;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic waitClocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Bits go out as start, data LSB-first, parity, stop; each held 16 clocks.
    // readyAt raises out_ready for exactly one cycle at that step; nSteps < 112 cuts the frame short.
    task automatic applyStimulus(input logic [3:0] data, input logic par, input logic stopBit,
                                 input int readyAt, input int nSteps);
        logic [6:0] bits;
        bits = {stopBit, par, data, 1'b0};
        for (int k = 0; k < nSteps; k++) begin
            @(negedge clk);
            if (k == 0) startCyc = cyc;
            if (k % 16 == 0) rx_i = bits[k / 16];
            if (readyAt >= 0 && k == readyAt) out_ready = 1'b1;
            if (readyAt >= 0 && k == readyAt + 1) out_ready = 1'b0;
        end
    endtask

    initial begin
        rst_n     = 1'b1;
        rx_i      = 1'b1;
        out_ready = 1'b0;
        #1 rst_n  = 1'b0;
        waitClocks(3);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_D", D, 0);
        checkOutput("rst_parity", parity, 0);
        checkOutput("rst_ferr", framing_err, 0);
        checkOutput("rst_overrun", overrun, 0);
        checkOutput("rst_busy", busy, 0);
        rst_n = 1'b1;
        waitClocks(3);

        $display("[TB] good frame 4'hB with out_ready high");
        out_ready = 1'b1;
        a0 = accCount; o0 = ovCount; f0 = feCount;
        applyStimulus(4'hB, 1'b1, 1'b1, -1, 112);
        waitClocks(4);
        checkOutput("t1_latency", riseCyc - startCyc, 107);
        checkOutput("t1_accepts", accCount - a0, 1);
        checkOutput("t1_D", accD, 4'hB);
        checkOutput("t1_parity", accPar, 1);
        checkOutput("t1_valid_cleared", out_valid, 0);
        checkOutput("t1_no_flags", (ovCount - o0) + (feCount - f0), 0);

        $display("[TB] false start glitch");
        out_ready = 1'b0;
        a0 = accCount; o0 = ovCount; f0 = feCount;
        @(negedge clk);
        rx_i = 1'b0;
        waitClocks(4);
        checkOutput("t2_busy_in_start", busy, 1);
        rx_i = 1'b1;
        waitClocks(20);
        checkOutput("t2_busy_idle", busy, 0);
        checkOutput("t2_valid", out_valid, 0);
        checkOutput("t2_no_flags", (ovCount - o0) + (feCount - f0), 0);

        $display("[TB] framing error then long break");
        a0 = accCount; f0 = feCount;
        applyStimulus(4'h5, 1'b0, 1'b0, -1, 112);
        waitClocks(40);
        checkOutput("t3_ferr_once", feCount - f0, 1);
        checkOutput("t3_busy_break", busy, 1);
        checkOutput("t3_valid", out_valid, 0);
        rx_i = 1'b1;
        waitClocks(4);
        checkOutput("t3_busy_released", busy, 0);
        checkOutput("t3_ferr_still_once", feCount - f0, 1);
        checkOutput("t3_no_accept", accCount - a0, 0);

        $display("[TB] overrun with out_ready low");
        out_ready = 1'b0;
        a0 = accCount; o0 = ovCount;
        applyStimulus(4'h3, 1'b0, 1'b1, -1, 112);
        applyStimulus(4'hC, 1'b0, 1'b1, -1, 112);
        waitClocks(2);
        checkOutput("t4_valid_held", out_valid, 1);
        checkOutput("t4_D_held", D, 4'h3);
        checkOutput("t4_overrun_once", ovCount - o0, 1);
        checkOutput("t4_no_accept_yet", accCount - a0, 0);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        waitClocks(3);
        checkOutput("t4_accepts", accCount - a0, 1);
        checkOutput("t4_accD", accD, 4'h3);
        checkOutput("t4_valid_cleared", out_valid, 0);

        $display("[TB] consume and reload in the same cycle");
        a0 = accCount; o0 = ovCount;
        applyStimulus(4'h3, 1'b0, 1'b1, -1, 112);
        applyStimulus(4'hC, 1'b1, 1'b1, 106, 112);
        waitClocks(2);
        checkOutput("t5_no_overrun", ovCount - o0, 0);
        checkOutput("t5_D", D, 4'hC);
        checkOutput("t5_parity", parity, 1);
        checkOutput("t5_valid", out_valid, 1);
        checkOutput("t5_old_consumed", accCount - a0, 1);
        checkOutput("t5_old_D", accD, 4'h3);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        waitClocks(2);
        checkOutput("t5_drained", out_valid, 0);

        $display("[TB] reset mid-frame");
        a0 = accCount;
        applyStimulus(4'h9, 1'b0, 1'b1, -1, 50);
        checkOutput("t6_busy_before", busy, 1);
        @(negedge clk);
        rst_n = 1'b0;
        rx_i  = 1'b1;
        #1;
        checkOutput("t6_rst_valid", out_valid, 0);
        checkOutput("t6_rst_D", D, 0);
        checkOutput("t6_rst_parity", parity, 0);
        checkOutput("t6_rst_busy", busy, 0);
        checkOutput("t6_rst_flags", {30'd0, framing_err, overrun}, 0);
        waitClocks(3);
        rst_n = 1'b1;
        waitClocks(3);
        out_ready = 1'b1;
        applyStimulus(4'h6, 1'b0, 1'b1, -1, 112);
        waitClocks(3);
        checkOutput("t6_accepts", accCount - a0, 1);
        checkOutput("t6_D", accD, 4'h6);
        checkOutput("t6_parity", accPar, 0);
        checkOutput("t6_valid_cleared", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
